message_scroller: RTL and testbench

MESSAGE_SCROLLER -- requirements
Module: message_scroller

---
 rtl/msg_display_pkg.sv | 20 ++
 rtl/scroll_tick_gen.sv | 43 ++++
 rtl/message_scroller.sv | 193 +++++++++++++++++++
 tb/tb_message_scroller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/msg_display_pkg.sv
// Shared types and constants for the message scroller.
// The scroller's FSM state type, the blank character and the default
// parameter values live here so the top and its tick generator agree.
package msg_display_pkg;

  // Scroller control states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Character used to blank the display and the message buffer
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Default configuration
  localparam int NUM_DIGITS_DEF = 6;
  localparam int MAX_LEN_DEF    = 32;
  localparam int TICK_DIV_DEF   = 25_000_000;

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll-rate divider: counts 0..TICK_DIV-1 while enabled and emits a
// one-cycle step pulse on the cycle the counter sits at TICK_DIV-1.
// clr returns the counter to 0 and suppresses the step in that cycle.
// The counter holds its value while en is low.
module scroll_tick_gen
  import msg_display_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count and step pulse
  always_comb begin
    step  = en && !clr && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = step ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/message_scroller.sv
// Scrolling message display driver.
// A MAX_LEN-character buffer is shown through a NUM_DIGITS-wide window that
// advances by one character every TICK_DIV clocks while in RUN.
// Strobe semantics: start, stop and wr_en are single-cycle strobes sampled on
// the rising clock edge; there is no backpressure, every strobe is taken in
// the cycle it is high. stop outranks start in the same cycle.
// The window register is refreshed the cycle after every position change
// (start or scroll step); wrap is asserted together with that refresh.
// Optional feature macro: MSG_SCROLL_REVERSE_EN adds a dir input that selects
// backward scrolling at each step.
module message_scroller
  import msg_display_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          wr_en,
  input  logic [$clog2(MAX_LEN)-1:0]    wr_addr,
  input  logic [7:0]                    wr_data,
  input  logic [$clog2(MAX_LEN):0]      msg_len,
`ifdef MSG_SCROLL_REVERSE_EN
  input  logic                          dir,
`endif
  output logic [8*NUM_DIGITS-1:0]       window,
  output logic                          busy,
  output logic                          wrap
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

  // Control state
  state_e                  state_q, state_d;
  logic [AW-1:0]           pos_q, pos_d;
  logic [LW-1:0]           len_q, len_d;
  logic                    upd_q, upd_d;             // window refresh due next edge
  logic                    wrap_pend_q, wrap_pend_d; // that refresh follows a wrap

  // Output registers
  logic [8*NUM_DIGITS-1:0] window_q, window_d;
  logic                    wrap_q, wrap_d;

  // Message buffer
  logic [7:0]              buf_q [MAX_LEN];
  logic [7:0]              buf_d [MAX_LEN];
  logic                    addr_ok;

  // Scroll control
  logic                    start_ok;
  logic                    tick_en;
  logic                    step;
  logic [AW-1:0]           next_pos;
  logic                    next_wrap;
  logic [LW-1:0]           win_idx;

  // Out-of-range addresses only exist when MAX_LEN is not a power of two
  generate
    if (MAX_LEN == (1 << AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_chk
      assign addr_ok = ({1'b0, wr_addr} < MAX_LEN_L);
    end
  endgenerate

  // A start counts only with a non-zero length and no competing stop
  assign start_ok = start && !stop && (msg_len != '0);
  assign tick_en  = (state_q == RUN) && !stop && !start_ok;

  scroll_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (tick_en),
    .step  (step)
  );

  // Position after one scroll step, and whether that step wraps
  always_comb begin
    next_pos  = ({1'b0, pos_q} == len_q - LW'(1)) ? '0 : pos_q + AW'(1);
    next_wrap = ({1'b0, pos_q} == len_q - LW'(1));
`ifdef MSG_SCROLL_REVERSE_EN
    if (dir) begin
      next_pos  = (pos_q == '0) ? AW'(len_q - LW'(1)) : pos_q - AW'(1);
      next_wrap = (pos_q == '0);
    end
`endif
  end

  // FSM next state: stop, then start, then scroll steps
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    len_d       = len_q;
    upd_d       = 1'b0;
    wrap_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          len_d   = (msg_len > MAX_LEN_L) ? MAX_LEN_L : msg_len;
          pos_d   = '0;
          upd_d   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start_ok) begin
          len_d = (msg_len > MAX_LEN_L) ? MAX_LEN_L : msg_len;
          pos_d = '0;
          upd_d = 1'b1;
        end else if (step) begin
          pos_d       = next_pos;
          upd_d       = 1'b1;
          wrap_pend_d = next_wrap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window refresh: leftmost digit shows buf[pos], then successive entries mod len
  always_comb begin
    window_d = window_q;
    wrap_d   = 1'b0;
    win_idx  = {1'b0, pos_q};
    if (upd_q) begin
      wrap_d = wrap_pend_q;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        window_d[8*(NUM_DIGITS-1-j) +: 8] = buf_q[win_idx[AW-1:0]];
        win_idx = win_idx + LW'(1);
        if (win_idx >= len_q) begin
          win_idx = '0;
        end
      end
    end
  end

  // Buffer write port, active in every state
  always_comb begin
    buf_d = buf_q;
    if (wr_en && addr_ok) begin
      buf_d[wr_addr] = wr_data;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      len_q       <= LW'(1);
      upd_q       <= 1'b0;
      wrap_pend_q <= 1'b0;
      window_q    <= {NUM_DIGITS{ASCII_SPACE}};
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      len_q       <= len_d;
      upd_q       <= upd_d;
      wrap_pend_q <= wrap_pend_d;
      window_q    <= window_d;
      wrap_q      <= wrap_d;
    end
  end

  // Buffer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_q[i] <= ASCII_SPACE;
      end
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign window = window_q;
  assign busy   = (state_q == RUN);
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller (NUM_DIGITS=6, MAX_LEN=32, TICK_DIV=4).
// Directed scenarios followed by random start/stop/write traffic, all checked
// against a behavioural model built from the scrolling rules.
module tb_message_scroller;

  localparam int ND = 6;
  localparam int ML = 32;
  localparam int TD = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start, stop, wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  msg_len;
  logic        dir;
  logic [47:0] window;
  logic        busy, wrap;

  int n_cmp = 0;
  int n_err = 0;

  message_scroller #(
    .NUM_DIGITS (ND),
    .MAX_LEN    (ML),
    .TICK_DIV   (TD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .msg_len (msg_len),
`ifdef MSG_SCROLL_REVERSE_EN
    .dir     (dir),
`endif
    .window  (window),
    .busy    (busy),
    .wrap    (wrap)
  );

  // Reference model state
  logic [7:0]  m_buf [ML];
  bit          m_run;
  int          m_pos, m_len, m_cyc;
  bit          m_chg, m_chg_wrap;
  logic [47:0] m_window;
  bit          m_wrap;
  logic [47:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [47:0] render(input int pos, input int len);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < ND; j++) begin
      r[8*(ND-1-j) +: 8] = m_buf[(pos + j) % len];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ML; i++) m_buf[i] = 8'h20;
    m_run = 0; m_pos = 0; m_len = 1; m_cyc = 0;
    m_chg = 0; m_chg_wrap = 0; m_wrap = 0;
    m_window = {ND{8'h20}};
  endtask

  // One clock edge of the model with the inputs present on that edge
  task automatic model_edge(input bit s, input bit p, input bit we, input int a,
                            input logic [7:0] d, input int ml, input bit dr);
    int np;
    m_wrap = m_chg && m_chg_wrap;
    if (m_chg) m_window = render(m_pos, m_len);
    m_chg = 0;
    m_chg_wrap = 0;
    if (p) begin
      m_run = 0;
    end else if (s && ml != 0) begin
      m_len = (ml > ML) ? ML : ml;
      m_pos = 0; m_cyc = 0; m_run = 1; m_chg = 1;
    end else if (m_run) begin
      m_cyc++;
      if (m_cyc % TD == 0) begin
        if (dr) begin
          np = (m_pos + m_len - 1) % m_len;
          m_chg_wrap = (m_pos == 0);
        end else begin
          np = (m_pos + 1) % m_len;
          m_chg_wrap = (np == 0);
        end
        m_pos = np;
        m_chg = 1;
      end
    end
    if (we && a < ML) m_buf[a] = d;
  endtask

  // Driver: apply inputs for one cycle, advance model, compare after the edge
  task automatic tick(input bit s, input bit p, input bit we, input int a,
                      input logic [7:0] d, input int ml, input bit dr);
    start = s; stop = p; wr_en = we; wr_addr = 5'(a); wr_data = d;
    msg_len = 6'(ml); dir = dr;
    @(posedge clk);
    model_edge(s, p, we, a, d, ml, dr);
    #1;
    check("window", 64'(window), 64'(m_window));
    check("busy", 64'(busy), 64'(m_run));
    check("wrap", 64'(wrap), 64'(m_wrap));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 8'h00, 0, 0);
  endtask

  // Asynchronous reset pulse asserted between clock edges
  task automatic do_reset();
    start = 0; stop = 0; wr_en = 0; msg_len = '0; dir = 0;
    reset = 1'b0;
    #2;
    check("rst_async_window", 64'(window), 64'h2020_2020_2020);
    check("rst_async_busy", 64'(busy), 64'd0);
    check("rst_async_wrap", 64'(wrap), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [63:0] hello;
  int          wraps;
  logic [47:0] hold;
  bit          rs, rp, rw, rd;
  int          r;

  initial begin
    reset = 1'b0; start = 0; stop = 0; wr_en = 0; wr_addr = '0;
    wr_data = '0; msg_len = '0; dir = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_window", 64'(window), 64'h2020_2020_2020);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_wrap", 64'(wrap), 64'd0);
    reset = 1'b1;
    idle(3);
    check("idle_window", 64'(window), 64'h2020_2020_2020);

    // Load "HELLO CP" and start an 8-character scroll
    hello = "HELLO CP";
    for (int i = 0; i < 8; i++) tick(0, 0, 1, i, hello[8*(7-i) +: 8], 0, 0);
    tick(1, 0, 0, 0, 8'h00, 8, 0);
    check("start_busy", 64'(busy), 64'd1);
    exp_q.push_back(48'h48454C4C4F20);  // "HELLO "
    exp_q.push_back(48'h454C4C4F2043);  // "ELLO C"
    idle(1);
    check("first_window", 64'(window), 64'(exp_q.pop_front()));
    idle(4);
    check("step1_window", 64'(window), 64'(exp_q.pop_front()));

    // Run on until the position wraps back to 0
    wraps = 0;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      if (wrap) begin
        wraps++;
        check("wrap_window", 64'(window), 64'h48454C4C4F20);
      end
    end
    check("wrap_count", 64'(wraps), 64'd1);

    // start and stop together: stop wins, window frozen
    idle(2);
    tick(1, 1, 0, 0, 8'h00, 8, 0);
    check("both_busy", 64'(busy), 64'd0);
    hold = m_window;
    idle(20);
    check("frozen_window", 64'(window), 64'(hold));
    check("frozen_busy", 64'(busy), 64'd0);

    // Reset in the middle of a run, then a zero-length start
    tick(1, 0, 0, 0, 8'h00, 5, 0);
    idle(7);
    do_reset();
    tick(1, 0, 0, 0, 8'h00, 0, 0);
    idle(3);
    check("zero_len_busy", 64'(busy), 64'd0);
    check("zero_len_window", 64'(window), 64'h2020_2020_2020);

    // Short message repeats across the window
    tick(0, 0, 1, 0, "A", 0, 0);
    tick(0, 0, 1, 1, "B", 0, 0);
    tick(1, 0, 0, 0, 8'h00, 2, 0);
    idle(1);
    check("repeat_window", 64'(window), 64'h414241424142);

    // Over-long msg_len clamps to the full buffer
    tick(1, 0, 0, 0, 8'h00, 45, 0);
    idle(TD * 3);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      r  = $urandom_range(0, 99);
      rs = (r < 4) || (r == 50);
      rp = (r >= 4 && r < 6) || (r == 50);
      rw = ($urandom_range(0, 3) == 0);
`ifdef MSG_SCROLL_REVERSE_EN
      rd = $urandom_range(0, 1) == 1;
`else
      rd = 1'b0;
`endif
      tick(rs, rp, rw, $urandom_range(0, ML - 1), 8'($urandom_range(8'h21, 8'h7e)),
           $urandom_range(0, 40), rd);
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
